// File: rtl/spi_reg_ctrl.sv
// -----------------------------------------------------------------------------
// spi_reg_ctrl
//
// Command sequencer between an SPI slave and a register bank. Each received
// 32-bit frame is checked for parity and address range. A valid frame then
// runs one handshaked read or write on the register bus, bounded by a timeout.
// The result is packed into a response word, which the SPI slave shifts out on
// the following frame.
//
// Request frame : [31] wr, [30:24] addr, [23] parity (XOR of all 32 bits = 0),
//                 [22:16] reserved, [15:0] wdata
// Response word : [31] wr, [30:24] addr, [23] err_parity, [22] err_timeout,
//                 [21] err_overrun, [20] err_addr, [19:16] seq, [15:0] data
//
// Ports
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   data_received  one-cycle strobe: incoming_data holds a complete frame
//   incoming_data  received frame
//   outgoing_data  response word for the next SPI message
//   reg_addr       register bus address
//   reg_wdata      register bus write data
//   reg_we         write request, held until ack or timeout
//   reg_re         read request, held until ack or timeout
//   reg_rdata      read data, valid while reg_ack is high
//   reg_ack        register bus completion, one cycle
//   busy           high whenever the sequencer is not idle
//   err_pulse      one-cycle pulse when a response with an error flag is loaded
// -----------------------------------------------------------------------------
module spi_reg_ctrl #(
   parameter int unsigned ADDR_LIMIT     = 64,
   parameter int unsigned TIMEOUT_CYCLES = 255   // 1..65535
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        data_received,
   input  logic [31:0] incoming_data,
   output logic [31:0] outgoing_data,
   output logic [6:0]  reg_addr,
   output logic [15:0] reg_wdata,
   output logic        reg_we,
   output logic        reg_re,
   input  logic [15:0] reg_rdata,
   input  logic        reg_ack,
   output logic        busy,
   output logic        err_pulse
);

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      ACCESS,
      RESPOND
   } state_t;

   // The last ACCESS cycle allowed is the one in which the counter holds
   // TIMEOUT_CYCLES-1. The counter starts at 0 in the first ACCESS cycle, so
   // the request strobe is high for exactly TIMEOUT_CYCLES cycles.
   localparam logic [15:0] CNT_LAST  = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]  ADDR_LIM8 = 8'(ADDR_LIMIT);

   state_t      state_q, state_d;
   logic [31:0] frame_q, frame_d;
   logic [31:0] out_q, out_d;
   logic [6:0]  reg_addr_q, reg_addr_d;
   logic [15:0] reg_wdata_q, reg_wdata_d;
   logic        we_q, we_d;
   logic        re_q, re_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] data_q, data_d;
   logic        err_par_q, err_par_d;
   logic        err_to_q, err_to_d;
   logic        err_addr_q, err_addr_d;
   logic        ovr_q, ovr_d;
   logic [3:0]  seq_q, seq_d;
   logic        err_pulse_q, err_pulse_d;

   // Frame decode, evaluated while the frame register is stable in CHECK.
   logic frame_wr;
   logic par_err;
   logic addr_err;
   logic ovr_now;
   logic any_err;

   assign frame_wr = frame_q[31];
   assign par_err  = ^frame_q;
   assign addr_err = ({1'b0, frame_q[30:24]} >= ADDR_LIM8);

   // An overrun strobe arriving during RESPOND itself is still reported in
   // the response being loaded, because the flag is cleared in that cycle.
   assign ovr_now = ovr_q | data_received;
   assign any_err = err_par_q | err_to_q | ovr_now | err_addr_q;

   // NOTE: every signal driven here gets its default first, so no path through
   // the case statement leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      frame_d     = frame_q;
      out_d       = out_q;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      we_d        = we_q;
      re_d        = re_q;
      cnt_d       = cnt_q;
      data_d      = data_q;
      err_par_d   = err_par_q;
      err_to_d    = err_to_q;
      err_addr_d  = err_addr_q;
      ovr_d       = ovr_q;
      seq_d       = seq_q;
      err_pulse_d = 1'b0;

      // Any frame arriving while a command is in flight is dropped.
      if (data_received && (state_q != IDLE)) begin
         ovr_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (data_received) begin
               frame_d = incoming_data;
               state_d = CHECK;
            end
         end

         CHECK: begin
            err_par_d  = par_err;
            err_addr_d = ~par_err & addr_err;   // parity error masks address error
            err_to_d   = 1'b0;
            data_d     = 16'h0000;
            if (par_err || addr_err) begin
               state_d = RESPOND;
            end else begin
               reg_addr_d  = frame_q[30:24];
               reg_wdata_d = frame_q[15:0];
               cnt_d       = 16'h0000;
               we_d        = frame_wr;
               re_d        = ~frame_wr;
               state_d     = ACCESS;
            end
         end

         ACCESS: begin
            // Ack in the final allowed cycle wins over the timeout.
            if (reg_ack) begin
               data_d  = frame_wr ? frame_q[15:0] : reg_rdata;
               we_d    = 1'b0;
               re_d    = 1'b0;
               state_d = RESPOND;
            end else if (cnt_q == CNT_LAST) begin
               err_to_d = 1'b1;
               data_d   = 16'h0000;
               we_d     = 1'b0;
               re_d     = 1'b0;
               state_d  = RESPOND;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         RESPOND: begin
            out_d = {frame_q[31:24], err_par_q, err_to_q, ovr_now, err_addr_q,
                     seq_q, any_err ? 16'h0000 : data_q};
            seq_d       = seq_q + 4'd1;
            ovr_d       = 1'b0;
            err_pulse_d = any_err;
            state_d     = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         frame_q     <= 32'h0;
         out_q       <= 32'h0;
         reg_addr_q  <= 7'h0;
         reg_wdata_q <= 16'h0;
         we_q        <= 1'b0;
         re_q        <= 1'b0;
         cnt_q       <= 16'h0;
         data_q      <= 16'h0;
         err_par_q   <= 1'b0;
         err_to_q    <= 1'b0;
         err_addr_q  <= 1'b0;
         ovr_q       <= 1'b0;
         seq_q       <= 4'h0;
         err_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_q     <= frame_d;
         out_q       <= out_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         we_q        <= we_d;
         re_q        <= re_d;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
         err_par_q   <= err_par_d;
         err_to_q    <= err_to_d;
         err_addr_q  <= err_addr_d;
         ovr_q       <= ovr_d;
         seq_q       <= seq_d;
         err_pulse_q <= err_pulse_d;
      end
   end

   assign outgoing_data = out_q;
   assign reg_addr      = reg_addr_q;
   assign reg_wdata     = reg_wdata_q;
   assign reg_we        = we_q;
   assign reg_re        = re_q;
   assign busy          = (state_q != IDLE);
   assign err_pulse     = err_pulse_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_ctrl
//
// Self-checking bench for spi_reg_ctrl. Expected responses, bus strobe lengths
// and latencies come from a transaction-level model of the command rules: one
// frame in, one response out, with error precedence, timeout and overrun
// handled arithmetically.
// -----------------------------------------------------------------------------
module tb_spi_reg_ctrl;

   localparam int T_OUT = 8;
   localparam int ALIM  = 64;

   logic        clk;
   logic        reset_n;
   logic        data_received;
   logic [31:0] incoming_data;
   logic [31:0] outgoing_data;
   logic [6:0]  reg_addr;
   logic [15:0] reg_wdata;
   logic        reg_we;
   logic        reg_re;
   logic [15:0] reg_rdata;
   logic        reg_ack;
   logic        busy;
   logic        err_pulse;

   int errors = 0;
   int checks = 0;
   logic [3:0] exp_seq = 4'h0;

   spi_reg_ctrl #(
      .ADDR_LIMIT    (ALIM),
      .TIMEOUT_CYCLES(T_OUT)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .data_received(data_received),
      .incoming_data(incoming_data),
      .outgoing_data(outgoing_data),
      .reg_addr     (reg_addr),
      .reg_wdata    (reg_wdata),
      .reg_we       (reg_we),
      .reg_re       (reg_re),
      .reg_rdata    (reg_rdata),
      .reg_ack      (reg_ack),
      .busy         (busy),
      .err_pulse    (err_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Build a frame; the parity bit is chosen so the XOR of all 32 bits is 0,
   // then optionally flipped.
   function automatic logic [31:0] make_frame(input logic wr, input logic [6:0] addr,
                                              input logic [15:0] wdata, input bit bad);
      logic [31:0] f;
      logic [6:0]  rsv;
      rsv   = 7'($urandom);
      f     = {wr, addr, 1'b0, rsv, wdata};
      f[23] = (^f) ^ bad;
      return f;
   endfunction

   // One complete transaction. d = ack position (0 = first strobe cycle),
   // negative = never ack. inject = drop an extra frame while busy.
   task automatic do_frame(input logic [31:0] f, input int d, input logic [15:0] rdata,
                           input bit inject, input string name);
      bit          p_err, a_err, access, tmo;
      int          exp_lat, exp_we, exp_re, strobe_len;
      logic [15:0] exp_data;
      logic [31:0] exp_resp;
      bit          any;
      int          iter, we_n, re_n;
      bit          done, bus_bad, pulse_early;
      logic [31:0] held;

      // Reference model of one command.
      p_err    = (^f) != 1'b0;
      a_err    = !p_err && (int'(f[30:24]) >= ALIM);
      access   = !p_err && !(int'(f[30:24]) >= ALIM);
      tmo      = access && (d < 0 || d >= T_OUT);
      strobe_len = access ? (tmo ? T_OUT : d + 1) : 0;
      exp_we   = f[31] ? strobe_len : 0;
      exp_re   = f[31] ? 0 : strobe_len;
      exp_lat  = !access ? 2 : (tmo ? T_OUT + 2 : d + 3);
      any      = p_err || a_err || tmo || inject;
      exp_data = any ? 16'h0 : (f[31] ? f[15:0] : rdata);
      exp_resp = {f[31:24], p_err, tmo, inject, a_err, exp_seq, exp_data};
      exp_seq  = exp_seq + 4'd1;

      @(posedge clk); #1;
      data_received = 1'b1;
      incoming_data = f;
      @(posedge clk); #1;
      data_received = 1'b0;
      incoming_data = $urandom;

      iter = 0; we_n = 0; re_n = 0;
      done = 0; bus_bad = 0; pulse_early = 0;
      while (!done && iter < 40) begin
         @(posedge clk); #1;
         data_received = 1'b0;
         reg_ack       = 1'b0;
         reg_rdata     = 16'($urandom);
         iter++;
         if (!busy) begin
            done = 1;
         end else begin
            if (err_pulse) pulse_early = 1;
            if (inject && iter == 1) begin
               data_received = 1'b1;
               incoming_data = $urandom;
            end
            if (reg_we || reg_re) begin
               if (reg_we) we_n++;
               if (reg_re) re_n++;
               if (reg_addr !== f[30:24] || reg_wdata !== f[15:0]) bus_bad = 1;
               if (d >= 0 && (we_n + re_n) == d + 1) begin
                  reg_ack   = 1'b1;
                  reg_rdata = rdata;
               end
            end else begin
               // Stray acks outside ACCESS must be ignored.
               reg_ack = 1'($urandom);
            end
         end
      end

      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s done: busy never dropped within 40 cycles", name);
      end
      checks++;
      if (iter !== exp_lat) begin
         errors++;
         $display("FAIL %s latency: got %0d cycles, expected %0d", name, iter, exp_lat);
      end
      checks++;
      if (we_n !== exp_we || re_n !== exp_re) begin
         errors++;
         $display("FAIL %s strobes: we=%0d re=%0d, expected we=%0d re=%0d",
                  name, we_n, re_n, exp_we, exp_re);
      end
      checks++;
      if (bus_bad !== 1'b0) begin
         errors++;
         $display("FAIL %s bus fields: reg_addr/reg_wdata differ from frame %h", name, f);
      end
      checks++;
      if (outgoing_data !== exp_resp) begin
         errors++;
         $display("FAIL %s response: got %h, expected %h", name, outgoing_data, exp_resp);
      end
      checks++;
      if (err_pulse !== any || pulse_early !== 1'b0) begin
         errors++;
         $display("FAIL %s err_pulse: got %b (early=%b), expected %b",
                  name, err_pulse, pulse_early, any);
      end

      // One cycle later the pulse is gone and the response holds.
      held = outgoing_data;
      reg_ack = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (err_pulse !== 1'b0 || outgoing_data !== exp_resp || held !== exp_resp) begin
         errors++;
         $display("FAIL %s hold: err_pulse=%b resp=%h, expected 0 and %h",
                  name, err_pulse, outgoing_data, exp_resp);
      end
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      exp_seq = 4'h0;
   endtask

   task automatic test_reset();
      data_received = 1'b0;
      incoming_data = 32'h0;
      reg_rdata     = 16'h0;
      reg_ack       = 1'b0;
      apply_reset();
      @(posedge clk); #1;
      checks++;
      if (outgoing_data !== 32'h0 || reg_addr !== 7'h0 || reg_wdata !== 16'h0) begin
         errors++;
         $display("FAIL reset data: out=%h addr=%h wdata=%h, expected all 0",
                  outgoing_data, reg_addr, reg_wdata);
      end
      checks++;
      if (reg_we !== 1'b0 || reg_re !== 1'b0 || busy !== 1'b0 || err_pulse !== 1'b0) begin
         errors++;
         $display("FAIL reset ctrl: we=%b re=%b busy=%b err_pulse=%b, expected 0",
                  reg_we, reg_re, busy, err_pulse);
      end
   endtask

   task automatic test_write();
      do_frame(make_frame(1'b1, 7'h05, 16'h1234, 1'b0), 2, 16'h0, 1'b0, "write");
   endtask

   task automatic test_read();
      do_frame(make_frame(1'b0, 7'h05, 16'h0, 1'b0), 0, 16'hBEEF, 1'b0, "read");
   endtask

   task automatic test_parity();
      do_frame(make_frame(1'b1, 7'h05, 16'hA5A5, 1'b1), 0, 16'h0, 1'b0, "parity");
   endtask

   task automatic test_addr();
      do_frame(make_frame(1'b1, 7'h50, 16'h5555, 1'b0), 0, 16'h0, 1'b0, "addr");
      do_frame(make_frame(1'b0, 7'h3F, 16'h0, 1'b0), 1, 16'h7777, 1'b0, "addr_last_ok");
      do_frame(make_frame(1'b0, 7'h40, 16'h0, 1'b0), 1, 16'h7777, 1'b0, "addr_first_bad");
      do_frame(make_frame(1'b0, 7'h50, 16'h0, 1'b1), 0, 16'h0, 1'b0, "parity_over_addr");
   endtask

   task automatic test_timeout();
      do_frame(make_frame(1'b0, 7'h11, 16'h0, 1'b0), -1, 16'h0, 1'b0, "timeout");
      do_frame(make_frame(1'b0, 7'h12, 16'h0, 1'b0), T_OUT - 1, 16'hC0DE, 1'b0, "ack_at_limit");
   endtask

   task automatic test_overrun();
      do_frame(make_frame(1'b0, 7'h20, 16'h0, 1'b0), 3, 16'h1111, 1'b1, "overrun");
      do_frame(make_frame(1'b0, 7'h21, 16'h0, 1'b0), 0, 16'h2222, 1'b0, "after_overrun");
   endtask

   task automatic test_seq_wrap();
      for (int i = 0; i < 17; i++) begin
         do_frame(make_frame(1'($urandom), 7'($urandom_range(0, 63)), 16'($urandom), 1'b0),
                  0, 16'($urandom), 1'b0, "seq_wrap");
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         logic [6:0] a;
         int         d;
         a = 7'($urandom_range(0, 79));
         d = int'($urandom_range(0, 10)) - 1;
         do_frame(make_frame(1'($urandom), a, 16'($urandom), ($urandom_range(0, 7) == 0)),
                  d, 16'($urandom), ($urandom_range(0, 4) == 0), "random");
      end
   endtask

   task automatic test_reset_mid_access();
      bit seen;
      @(posedge clk); #1;
      data_received = 1'b1;
      incoming_data = make_frame(1'b0, 7'h09, 16'h0, 1'b0);
      @(posedge clk); #1;
      data_received = 1'b0;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(posedge clk); #1;
         if (reg_re) seen = 1;
      end
      checks++;
      if (seen !== 1'b1) begin
         errors++;
         $display("FAIL midreset setup: reg_re never rose");
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (reg_re !== 1'b0 || reg_we !== 1'b0 || outgoing_data !== 32'h0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset: re=%b we=%b out=%h busy=%b, expected all 0",
                  reg_re, reg_we, outgoing_data, busy);
      end
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      exp_seq = 4'h0;
      do_frame(make_frame(1'b1, 7'h0A, 16'hFACE, 1'b0), 1, 16'h0, 1'b0, "after_midreset");
   endtask

   initial begin
      reset_n = 1'b0;
      test_reset();
      test_write();
      test_read();
      test_parity();
      test_addr();
      test_timeout();
      test_overrun();
      test_seq_wrap();
      test_random();
      test_reset_mid_access();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
